// File: rtl/regfile_pkg.sv
// Shared widths and types for the general-purpose register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: address mux plus write-through bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0]                   rdAddr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  bank,
  input  logic [(2**ADDR_W)-1:0]              pend,
  input  logic                                wrEn,
  input  logic [ADDR_W-1:0]                   wrAddr,
  input  logic [DATA_W-1:0]                   wrData,
  output logic [DATA_W-1:0]                   rdData,
  output logic                                rdPending
);

  logic isZero;
  logic bypassHit;

  // Select stored value, override with in-flight write, force reg 0 to read as zero
  always_comb begin
    isZero    = ZERO_REG && (rdAddr == '0);
    bypassHit = BYPASS && wrEn && (rdAddr == wrAddr) && !isZero;
    rdData    = bank[rdAddr];
    rdPending = pend[rdAddr];
    if (bypassHit) begin
      rdData    = wrData;
      rdPending = 1'b0;
    end
    if (isZero) begin
      rdData    = '0;
      rdPending = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with per-register pending scoreboard for RAW detection.
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_req,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ack,
  output logic [ADDR_W:0]          pending_cnt
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0][DATA_W-1:0] bank;
  logic [DEPTH-1:0]             pend;
  logic [DEPTH-1:0]             pendNext;
  logic [CNT_W-1:0]             cntNext;
  logic                         wrValid;
  logic                         rsvIsZero;
  logic                         clearing;
  logic                         rsvSet;
  logic                         cntInc;
  logic                         cntDec;

  // Reservation handshake and next scoreboard state; a same-cycle re-reserve beats the clear
  always_comb begin
    wrValid   = wr_en && !(ZERO_REG && (wr_addr == '0));
    rsvIsZero = ZERO_REG && (rsv_addr == '0);
    clearing  = wr_en && (wr_addr == rsv_addr);
    rsv_ack   = rsv_req && (rsvIsZero || !pend[rsv_addr] || clearing);
    rsvSet    = rsv_ack && !rsvIsZero;
    cntInc    = rsvSet && !pend[rsv_addr];
    cntDec    = wrValid && pend[wr_addr] && !(rsvSet && (rsv_addr == wr_addr));
    pendNext  = pend;
    if (wrValid) begin
      pendNext[wr_addr] = 1'b0;
    end
    if (rsvSet) begin
      pendNext[rsv_addr] = 1'b1;
    end
    cntNext = pending_cnt + CNT_W'(cntInc) - CNT_W'(cntDec);
  end

  // Register bank, pending bits and their running population count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank        <= '0;
      pend        <= '0;
      pending_cnt <= '0;
    end else begin
      if (wrValid) begin
        bank[wr_addr] <= wr_data;
      end
      pend        <= pendNext;
      pending_cnt <= cntNext;
    end
  end

  // One mux/bypass slice per read port
  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) uPort (
      .rdAddr    (rd_addr[k*ADDR_W +: ADDR_W]),
      .bank      (bank),
      .pend      (pend),
      .wrEn      (wr_en),
      .wrAddr    (wr_addr),
      .wrData    (wr_data),
      .rdData    (rd_data[k*DATA_W +: DATA_W]),
      .rdPending (rd_pending[k])
    );
  end

endmodule
